// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types, constants and helpers for the stream mux arbiter and the
// capture taps that feed it.
//   arb_state_t   : arbiter FSM states (IDLE, LOCKED)
//   STREAM_TYPE_* : tap identifiers, one per AXI channel
//   rr_pick()     : round-robin priority search used by rr_priority_picker
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Tap identifiers; the tap index on the arbiter equals its stream type.
    localparam logic [2:0] STREAM_TYPE_AR = 3'd0;
    localparam logic [2:0] STREAM_TYPE_R  = 3'd1;
    localparam logic [2:0] STREAM_TYPE_AW = 3'd2;
    localparam logic [2:0] STREAM_TYPE_W  = 3'd3;
    localparam logic [2:0] STREAM_TYPE_B  = 3'd4;

    // Upper bound on requesters the picker helper can handle.
    localparam int RR_MAX_SRC = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first requester at or after ptr, wrapping modulo num_src.
    // Walks offsets from highest to lowest so the smallest offset wins last.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_SRC-1:0] req,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    num_src
    );
        rr_pick_t            res;
        logic [RR_IDX_W-1:0] pos;
        res = '0;
        pos = '0;
        for (int off = RR_MAX_SRC - 1; off >= 0; off--) begin
            if (off < num_src) begin
                pos = RR_IDX_W'((int'(ptr) + off) % num_src);
                if (req[pos]) begin
                    res.found = 1'b1;
                    res.idx   = pos;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotate/priority encoder: finds the first set request bit
// starting at ptr and wrapping around NUM_SRC.
//   req   : request vector, one bit per source
//   ptr   : index with highest priority this cycle
//   idx   : winning index (0 when nothing requests)
//   found : at least one request is set
// -----------------------------------------------------------------------------
module rr_priority_picker
    import stream_arb_pkg::*;
#(
    parameter int NUM_SRC      = 5,
    parameter int SRC_ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]      req,
    input  logic [SRC_ID_WIDTH-1:0] ptr,
    output logic [SRC_ID_WIDTH-1:0] idx,
    output logic                    found
);

    rr_pick_t pick_s;
    logic     unused_idx_s;

    // Round-robin search over the zero-extended request vector.
    always_comb begin
        pick_s = rr_pick(RR_MAX_SRC'(req), RR_IDX_W'(ptr), NUM_SRC);
    end

    assign idx          = pick_s.idx[SRC_ID_WIDTH-1:0];
    assign found        = pick_s.found;
    assign unused_idx_s = ^pick_s.idx;

endmodule

// File: rtl/stream_mux_arbiter.sv
// -----------------------------------------------------------------------------
// stream_mux_arbiter
// Shares one outbound AXI-Stream link among NUM_SRC capture taps. A packet is
// granted round-robin and the link stays locked on that tap until its last
// beat is accepted downstream. Routing is combinational (no added latency).
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   src_valid/in_progress/last/data : per-tap beat interface (src 0 at LSBs)
//   src_ready            : per-tap ready, one-hot or zero
//   m_axis_t*            : outbound stream
//   grant_id             : current winner, else the locked/last-locked tap
//   busy                 : high while locked onto a packet
//   proto_err            : sticky, a non-granted tap claimed to be mid-packet
//   pkt_count            : per-tap packet counters (only with the macro below)
//
// Build option: define STREAM_ARB_PKT_COUNT_EN to add pkt_count.
// -----------------------------------------------------------------------------
module stream_mux_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_SRC      = 5,
    parameter int DATA_WIDTH   = 128,
    parameter int SRC_ID_WIDTH = $clog2(NUM_SRC),
    parameter int CNT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_in_progress,
    input  logic [NUM_SRC-1:0]            src_last,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [SRC_ID_WIDTH-1:0]       grant_id,
    output logic                          busy,
    output logic                          proto_err
`ifdef STREAM_ARB_PKT_COUNT_EN
    ,
    output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_count
`endif
);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_LOCKED = LOCKED;
    localparam logic [NUM_SRC-1:0] ONE_HOT_0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

    logic [0:0]              state_r;
    logic [SRC_ID_WIDTH-1:0] rr_ptr_r;
    logic [SRC_ID_WIDTH-1:0] lock_id_r;
    logic                    proto_err_r;

    logic [SRC_ID_WIDTH-1:0] pick_idx_s;
    logic                    pick_found_s;
    logic                    locked_s;
    logic [SRC_ID_WIDTH-1:0] sel_s;
    logic                    sel_valid_s;
    logic                    out_valid_s;
    logic                    hs_s;
    logic [SRC_ID_WIDTH-1:0] next_ptr_s;
    logic [NUM_SRC-1:0]      err_mask_s;

    rr_priority_picker #(
        .NUM_SRC      (NUM_SRC),
        .SRC_ID_WIDTH (SRC_ID_WIDTH)
    ) u_picker (
        .req   (src_valid),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign locked_s = (state_r == ST_LOCKED);

    // Select the routed source: fixed while locked, round-robin winner when idle.
    always_comb begin
        sel_s       = pick_idx_s;
        sel_valid_s = pick_found_s;
        if (locked_s) begin
            sel_s       = lock_id_r;
            sel_valid_s = src_valid[lock_id_r];
        end else begin
            sel_s       = pick_idx_s;
            sel_valid_s = pick_found_s;
        end
    end

    // Outputs are gated by resetn so nothing leaks while reset is held.
    assign out_valid_s = resetn & sel_valid_s;
    assign hs_s        = out_valid_s & m_axis_tready;

    // Outbound mux and per-tap ready; payload is zeroed when not valid.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        src_ready     = '0;
        if (out_valid_s) begin
            m_axis_tdata = src_data[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tlast = src_last[sel_s];
            src_ready    = m_axis_tready ? (ONE_HOT_0 << sel_s) : '0;
        end else begin
            m_axis_tdata = '0;
            m_axis_tlast = 1'b0;
            src_ready    = '0;
        end
    end

    assign m_axis_tvalid = out_valid_s;

    // Pointer advance with wrap at the last source.
    always_comb begin
        if (sel_s == SRC_ID_WIDTH'(NUM_SRC - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = sel_s + SRC_ID_WIDTH'(1);
        end
    end

    // Taps other than the locked one must not claim to be mid-packet.
    always_comb begin
        if (locked_s) begin
            err_mask_s = src_in_progress & ~(ONE_HOT_0 << lock_id_r);
        end else begin
            err_mask_s = src_in_progress;
        end
    end

    // Grant indication: live winner when idle with requests, else lock_id.
    always_comb begin
        if (!resetn) begin
            grant_id = '0;
        end else if (!locked_s && pick_found_s) begin
            grant_id = pick_idx_s;
        end else begin
            grant_id = lock_id_r;
        end
    end

    assign busy      = locked_s;
    assign proto_err = proto_err_r;

    // Arbitration FSM, round-robin pointer, lock index and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            lock_id_r   <= '0;
            proto_err_r <= 1'b0;
        end else begin
            if (hs_s) begin
                if (!locked_s) begin
                    if (m_axis_tlast) begin
                        rr_ptr_r <= next_ptr_s;
                    end else begin
                        state_r   <= ST_LOCKED;
                        lock_id_r <= pick_idx_s;
                    end
                end else if (m_axis_tlast) begin
                    state_r  <= ST_IDLE;
                    rr_ptr_r <= next_ptr_s;
                end
            end
            if (|err_mask_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

`ifdef STREAM_ARB_PKT_COUNT_EN
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_r;

        // Count completed packets from this tap; wraps naturally.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_r <= '0;
            end else if (hs_s && m_axis_tlast && (sel_s == SRC_ID_WIDTH'(g))) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end

        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_arbiter
// Directed scenarios followed by random traffic. Every cycle the DUT outputs
// are compared against a behavioural arbiter model kept in plain integers.
// -----------------------------------------------------------------------------
module tb_stream_mux_arbiter;

    localparam int N   = 5;
    localparam int DW  = 128;
    localparam int IDW = 3;
    localparam int CW  = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_in_progress;
    logic [N-1:0]    src_last;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            proto_err;
`ifdef STREAM_ARB_PKT_COUNT_EN
    logic [N*CW-1:0] pkt_count;
`endif

    stream_mux_arbiter dut (
        .clk             (clk),
        .resetn          (resetn),
        .src_valid       (src_valid),
        .src_in_progress (src_in_progress),
        .src_last        (src_last),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .grant_id        (grant_id),
        .busy            (busy),
        .proto_err       (proto_err)
`ifdef STREAM_ARB_PKT_COUNT_EN
        ,
        .pkt_count       (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_locked;
    int m_lock_id;
    int m_rr;
    int m_err;
    int m_cnt [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked  = 0;
        m_lock_id = 0;
        m_rr      = 0;
        m_err     = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N-1:0] ip,
                        input logic [N-1:0] l, input logic rdy);
        int           sel;
        bit           ev;
        logic [N-1:0] exp_ready;
        logic [DW-1:0] exp_data;
        int           exp_gid;
        @(negedge clk);
        resetn          = rst;
        src_valid       = v;
        src_in_progress = ip;
        src_last        = l;
        m_axis_tready   = rdy;
        for (int i = 0; i < N; i++)
            src_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (!rst) model_reset();
        sel = 0;
        ev  = 0;
        if (m_locked != 0) begin
            sel = m_lock_id;
            ev  = v[sel];
        end else begin
            for (int off = 0; off < N; off++) begin
                int s;
                s = (m_rr + off) % N;
                if (!ev && v[s]) begin
                    ev  = 1;
                    sel = s;
                end
            end
        end
        if (!rst) ev = 0;
        exp_ready = (ev && rdy) ? N'(1 << sel) : '0;
        exp_data  = ev ? src_data[sel*DW +: DW] : '0;
        if (!rst) exp_gid = 0;
        else if (m_locked == 0 && ev) exp_gid = sel;
        else exp_gid = m_lock_id;

        check_val("tvalid",    m_axis_tvalid, ev);
        check_val("tdata",     m_axis_tdata, exp_data);
        check_val("tlast",     m_axis_tlast, ev ? l[sel] : 1'b0);
        check_val("src_ready", src_ready, exp_ready);
        check_val("grant_id",  grant_id, exp_gid);
        check_val("busy",      busy, m_locked != 0);
        check_val("proto_err", proto_err, m_err != 0);
`ifdef STREAM_ARB_PKT_COUNT_EN
        for (int i = 0; i < N; i++)
            check_val("pkt_count", pkt_count[i*CW +: CW], m_cnt[i]);
`endif
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++)
                if (ip[i] && !(m_locked != 0 && i == m_lock_id)) m_err = 1;
            if (ev && rdy) begin
                if (l[sel]) m_cnt[sel]++;
                if (m_locked == 0) begin
                    if (l[sel]) m_rr = (sel + 1) % N;
                    else begin
                        m_locked  = 1;
                        m_lock_id = sel;
                    end
                end else if (l[sel]) begin
                    m_locked = 0;
                    m_rr     = (sel + 1) % N;
                end
            end
        end
    endtask

    initial begin
        int beats;
        resetn          = 1'b0;
        src_valid       = '0;
        src_in_progress = '0;
        src_last        = '0;
        src_data        = '0;
        m_axis_tready   = 1'b0;
        model_reset();

        // Reset held while a tap is valid: outputs must stay low.
        step(1'b0, 5'b00100, 5'b00000, 5'b00100, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        // Source 2, three-beat packet.
        step(1'b1, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b00100, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1);
        step(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1);

        // Fresh pointer, then sources 0,1,4 with single-beat packets.
        step(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        for (int k = 0; k < 4; k++)
            step(1'b1, 5'b10011, 5'b00000, 5'b10011, 1'b1);

        // Source 1 locked, source 3 requests mid-packet.
        step(1'b1, 5'b00010, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b01010, 5'b00010, 5'b00000, 1'b1);
        step(1'b1, 5'b01000, 5'b00010, 5'b00000, 1'b1);
        step(1'b1, 5'b01010, 5'b00010, 5'b00010, 1'b1);
        step(1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1);

        // Source 2, four beats with tready toggling.
        beats = 0;
        for (int cyc = 0; cyc < 20 && beats < 4; cyc++) begin
            step(1'b1, 5'b00100, (beats > 0) ? 5'b00100 : 5'b00000,
                 (beats == 3) ? 5'b00100 : 5'b00000, (cyc % 2) == 0);
            if ((cyc % 2) == 0) beats++;
        end

        // Reset pulse in the middle of a packet, then restart from source 0.
        step(1'b1, 5'b00001, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00001, 5'b00001, 5'b00000, 1'b1);
        step(1'b1, 5'b00011, 5'b00000, 5'b00011, 1'b1);

        // Source 2 claims in_progress while source 0 is locked.
        step(1'b1, 5'b00001, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b00001, 5'b00101, 5'b00000, 1'b1);
        step(1'b1, 5'b00001, 5'b00001, 5'b00001, 1'b1);
        step(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);

        // Three packets from source 4 after a clean reset.
        step(1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b0);
        step(1'b1, 5'b10000, 5'b00000, 5'b10000, 1'b1);
        step(1'b1, 5'b10000, 5'b00000, 5'b00000, 1'b1);
        step(1'b1, 5'b10000, 5'b10000, 5'b10000, 1'b1);
        step(1'b1, 5'b10000, 5'b00000, 5'b10000, 1'b1);
        step(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
`ifdef STREAM_ARB_PKT_COUNT_EN
        check_val("pkt_count_src4", pkt_count[4*CW +: CW], 3);
`endif

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            logic [N-1:0] ip;
            ip = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
            step($urandom_range(0, 99) != 0, N'($urandom), ip,
                 N'($urandom & $urandom), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_arbiter.md
Name: stream_mux_arbiter

Overview:
- Shares one outbound AXI-Stream link among NUM_SRC per-channel capture taps (AR, R, AW, W, B).
- Each tap presents valid/in_progress/last/data and receives a ready that gates its AXI passthrough.
- The arbiter grants the link to one tap per packet, round-robin, and locks onto that tap until its last beat is accepted.
- Sits between the taps and the Ethernet framing stage.

Parameters:
- NUM_SRC, 5, number of requesting taps.
- DATA_WIDTH, 128, stream beat width.
- SRC_ID_WIDTH, $clog2(NUM_SRC), width of grant index.
- CNT_WIDTH, 32, width of optional packet counters.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous assert, active-low reset.
- src_valid  in  NUM_SRC  tap has a beat.
- src_in_progress  in  NUM_SRC  tap is mid-packet.
- src_last  in  NUM_SRC  tap beat is final of packet.
- src_data  in  NUM_SRC*DATA_WIDTH  tap beats, packed, src 0 at LSBs.
- src_ready  out  NUM_SRC  per-tap ready (one-hot or zero).
- m_axis_tdata  out  DATA_WIDTH  outbound beat.
- m_axis_tvalid  out  1  outbound valid.
- m_axis_tlast  out  1  outbound last.
- m_axis_tready  in  1  downstream ready.
- grant_id  out  SRC_ID_WIDTH  current/last granted source.
- busy  out  1  high in LOCKED.
- proto_err  out  1  sticky: a non-granted tap asserted in_progress.

Behaviour:
- Reset (async, resetn low):
  - state=IDLE, rr_ptr=0, lock_id=0, proto_err=0.
  - src_ready=0, m_axis_tvalid=0, grant_id=0.
  - Outputs are forced low while resetn is low, even though taps may be valid.
- Winner: first set bit of src_valid scanning from rr_ptr upward, wrapping modulo NUM_SRC. Combinational, zero added latency.
- IDLE:
  - Route winner data/valid/last to m_axis_*; src_ready[winner]=m_axis_tready; all other src_ready=0.
  - No valid source: tvalid=0, src_ready=0.
  - Handshake (tvalid&&tready) with tlast=0: go to LOCKED, lock_id<=winner.
  - Handshake with tlast=1 (single-beat packet): stay IDLE, rr_ptr<=winner+1 (wrap).
- LOCKED:
  - Mux fixed at lock_id; src_ready[lock_id]=m_axis_tready; other sources ignored even if valid.
  - Handshake with tlast=1: go to IDLE, rr_ptr<=lock_id+1 (wrap at NUM_SRC-1 -> 0).
  - tvalid low inside a packet (tap stalled): remain LOCKED, no timeout.
- grant_id = winner in IDLE when any source is valid, else lock_id; holds its value when idle with no requests.
- tdata/tlast are don't-care when tvalid=0; drive zero.
- proto_err:
  - Set when src_in_progress[i]=1 for any i≠lock_id while LOCKED, or for any i while IDLE.
  - Cleared only by reset.
  - Does not alter arbitration.
- Simultaneous requests: rotation guarantees each valid tap is served within NUM_SRC packets.
- src_valid dropping before handshake in IDLE: winner may change the next cycle (taps do not retract in practice; not an error).
- Reset mid-packet: returns to IDLE immediately; the partial packet is abandoned and downstream sees tvalid drop.

Optional Feature:
- Macro: STREAM_ARB_PKT_COUNT_EN.
- Defined:
  - Adds output pkt_count [NUM_SRC*CNT_WIDTH], one counter per source.
  - A counter increments on each accepted beat with tlast=1 from that source and wraps at 2^CNT_WIDTH.
  - Counters reset to 0 asynchronously.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_arb_pkg:
  - enum arb_state_t {IDLE, LOCKED}.
  - Function rr_pick(req, ptr) returning index and found flag.
  - STREAM_TYPE constants shared with the taps.
- One sub-module is natural: rr_priority_picker, the combinational rotate/priority encoder parameterised on NUM_SRC.

Test Plan:
- Single source 2, 3-beat packet (last on beat 3), tready=1 -> beats appear in 3 consecutive cycles, busy high after beat 1 until beat 3, rr_ptr=3.
- Sources 0, 1, 4 valid together, 1-beat packets each, tready=1 -> grant order 0, 1, 4, then 0; src_ready one-hot each cycle.
- Source 1 locked mid-packet, source 3 asserts valid -> src_ready[3]=0 until source 1's last handshake; source 3 granted the next cycle.
- tready toggled 1,0,1,0 during a 4-beat packet -> no beat lost or duplicated; src_ready mirrors tready.
- Async resetn pulse mid-packet -> src_ready and tvalid drop in the same cycle, state IDLE, proto_err=0; next packet starts from source 0.
- Source 2 in_progress=1 while source 0 locked -> proto_err=1 and sticky after the packet. With STREAM_ARB_PKT_COUNT_EN, 3 packets from source 4 -> pkt_count[4]=3.
